// File: rtl/ptw_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ptw_req_scheduler
// Description : Round-robin scheduler sharing one downstream page-walk
//               request port among N requesters, with at most one
//               transaction in flight. The granted request is captured,
//               presented downstream with a valid/ready handshake, and its
//               single response is routed back to the owner by stored index.
//               A kill squashes the in-flight response; the downstream
//               transaction itself always completes.
// Ports       : clock, reset (async, active-low)
//               io_in_valid/io_in_addr/io_in_ready  - per-requester request
//               io_out_valid/io_out_ready/io_out_addr/io_out_id - downstream
//               io_resp_valid/io_resp_data          - downstream response
//               io_resp_out_valid/io_resp_out_data  - routed response
//               io_kill, io_busy                    - squash / status
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_req_scheduler #(
    parameter int N      = 2,
    parameter int ADDR_W = 27,
    parameter int DATA_W = 64,
    parameter int ID_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N-1:0]          io_in_valid,
    input  logic [N*ADDR_W-1:0]   io_in_addr,
    output logic [N-1:0]          io_in_ready,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [ADDR_W-1:0]     io_out_addr,
    output logic [ID_W-1:0]       io_out_id,
    input  logic                  io_resp_valid,
    input  logic [DATA_W-1:0]     io_resp_data,
    output logic [N-1:0]          io_resp_out_valid,
    output logic [DATA_W-1:0]     io_resp_out_data,
    input  logic                  io_kill,
    output logic                  io_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] c_LAST_IDX = ID_W'(N - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic              r_squash;

    logic [ID_W:0]     w_scan;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic              w_found;
    logic              w_accept;
    logic [ADDR_W-1:0] w_sel_addr;

    // Rotating priority scan: start at r_ptr, wrap modulo N. The extra bit
    // in w_scan keeps ptr+k from overflowing before the explicit wrap.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int k = 0; k < N; k++) begin
            w_scan = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_scan >= (ID_W+1)'(N)) begin
                w_scan = w_scan - (ID_W+1)'(N);
            end
            if (!w_found && io_in_valid[w_scan[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[ID_W-1:0];
            end
        end
    end

    assign w_accept    = (r_state == ST_IDLE) && w_found;
    assign io_in_ready = w_accept ? (N'(1) << w_winner) : '0;
    assign w_sel_addr  = io_in_addr[w_winner*ADDR_W +: ADDR_W];

    // Explicit wrap keeps the pointer inside 0..N-1 for non-power-of-2 N.
    assign w_ptr_nxt = (w_winner == c_LAST_IDX) ? '0 : (w_winner + 1'b1);

    always_comb begin
        w_state_nxt       = r_state;
        io_out_valid      = 1'b0;
        io_resp_out_valid = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                io_out_valid = 1'b1;
                if (io_out_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (io_resp_valid) begin
                    // A kill in the response cycle itself also swallows it.
                    if (!r_squash && !io_kill) begin
                        io_resp_out_valid = N'(1) << r_id;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_addr   <= '0;
            r_squash <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr   <= w_sel_addr;
                r_id     <= w_winner;
                r_ptr    <= w_ptr_nxt;
                // Accept only happens in IDLE, where kill is meaningless, so
                // a coincident kill never squashes the new transaction.
                r_squash <= 1'b0;
            end else if (io_kill && (r_state != ST_IDLE)) begin
                r_squash <= 1'b1;
            end
        end
    end

    assign io_out_addr      = r_addr;
    assign io_out_id        = r_id;
    assign io_resp_out_data = io_resp_data;
    assign io_busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ptw_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptw_req_scheduler
// Description : Self-checking bench for ptw_req_scheduler. Two instances:
//               N=2 for arbitration, backpressure, kill, spurious response
//               and reset; N=3 for non-power-of-2 pointer wrap.
//               Expected grants come from a bench-side round-robin model and
//               flow through a scoreboard queue to the downstream checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptw_req_scheduler;

    localparam int AW = 27;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // N=2 instance
    logic [1:0]      a_valid, a_in_ready, a_resp_out_valid;
    logic [2*AW-1:0] a_addr;
    logic            a_out_valid, a_out_ready, a_resp_valid, a_kill, a_busy;
    logic [AW-1:0]   a_out_addr;
    logic [0:0]      a_out_id;
    logic [DW-1:0]   a_resp_data, a_resp_out_data;

    // N=3 instance
    logic [2:0]      b_valid, b_in_ready, b_resp_out_valid;
    logic [3*AW-1:0] b_addr;
    logic            b_out_valid, b_out_ready, b_resp_valid, b_kill, b_busy;
    logic [AW-1:0]   b_out_addr;
    logic [1:0]      b_out_id;
    logic [DW-1:0]   b_resp_data, b_resp_out_data;

    ptw_req_scheduler #(.N(2), .ADDR_W(AW), .DATA_W(DW)) u_dut2 (
        .clock             (clk),
        .reset             (rst_n),
        .io_in_valid       (a_valid),
        .io_in_addr        (a_addr),
        .io_in_ready       (a_in_ready),
        .io_out_valid      (a_out_valid),
        .io_out_ready      (a_out_ready),
        .io_out_addr       (a_out_addr),
        .io_out_id         (a_out_id),
        .io_resp_valid     (a_resp_valid),
        .io_resp_data      (a_resp_data),
        .io_resp_out_valid (a_resp_out_valid),
        .io_resp_out_data  (a_resp_out_data),
        .io_kill           (a_kill),
        .io_busy           (a_busy)
    );

    ptw_req_scheduler #(.N(3), .ADDR_W(AW), .DATA_W(DW)) u_dut3 (
        .clock             (clk),
        .reset             (rst_n),
        .io_in_valid       (b_valid),
        .io_in_addr        (b_addr),
        .io_in_ready       (b_in_ready),
        .io_out_valid      (b_out_valid),
        .io_out_ready      (b_out_ready),
        .io_out_addr       (b_out_addr),
        .io_out_id         (b_out_id),
        .io_resp_valid     (b_resp_valid),
        .io_resp_data      (b_resp_data),
        .io_resp_out_valid (b_resp_out_valid),
        .io_resp_out_data  (b_resp_out_data),
        .io_kill           (b_kill),
        .io_busy           (b_busy)
    );

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   resp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ptr2  = 0;
    int   m_ptr3  = 0;

    // Reference arbiter: first valid requester at or after ptr, modulo n.
    function automatic int rr_pick(input logic [7:0] v, input int ptr, input int n);
        int i;
        for (int k = 0; k < n; k++) begin
            i = (ptr + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = '0; a_addr = '0; a_out_ready = 1'b0; a_resp_valid = 1'b0;
        a_resp_data = '0; a_kill = 1'b0;
        b_valid = '0; b_addr = '0; b_out_ready = 1'b0; b_resp_valid = 1'b0;
        b_resp_data = '0; b_kill = 1'b0;
        #1;
        n_tests++;
        if ({a_out_valid, a_busy, a_resp_out_valid, a_in_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_a: got %b expected 000000",
                     {a_out_valid, a_busy, a_resp_out_valid, a_in_ready});
        end
        n_tests++;
        if ({b_out_valid, b_busy, b_resp_out_valid, b_in_ready} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_b: got %b expected 00000000",
                     {b_out_valid, b_busy, b_resp_out_valid, b_in_ready});
        end
        step();
        step();
        rst_n = 1'b1;
        m_ptr2 = 0;
        m_ptr3 = 0;
        step();
        n_tests++;
        if ({a_out_valid, a_busy, a_out_id, a_out_addr} !== {3'b000, 27'h0}) begin
            n_fail++;
            $display("FAIL reset_release: got valid=%b busy=%b id=%h addr=%h expected all zero",
                     a_out_valid, a_busy, a_out_id, a_out_addr);
        end
    endtask

    task automatic test_round_robin();
        int w;
        int r;
        exp_t e;
        logic [DW-1:0] d;
        a_addr = {27'h7FFFFFF, 27'h0000123};
        a_valid = 2'b11;
        a_out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            #1;
            w = rr_pick({6'b0, a_valid}, m_ptr2, 2);
            n_tests++;
            if (a_in_ready !== 2'(1 << w)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", t, a_in_ready, 2'(1 << w));
            end
            e.id = w;
            e.addr = a_addr[w*AW +: AW];
            sb_q.push_back(e);
            m_ptr2 = (w + 1) % 2;
            step();
            e = sb_q.pop_front();
            n_tests++;
            if ({a_out_valid, a_out_id, a_out_addr, a_in_ready} !== {1'b1, 1'(e.id), e.addr, 2'b00}) begin
                n_fail++;
                $display("FAIL rr_issue[%0d]: got v=%b id=%h addr=%h rdy=%b expected v=1 id=%0d addr=%h rdy=00",
                         t, a_out_valid, a_out_id, a_out_addr, a_in_ready, e.id, e.addr);
            end
            resp_q.push_back(e.id);
            step();
            d = {32'hCAFE_0000, 32'(t)};
            a_resp_data = d;
            a_resp_valid = 1'b1;
            #1;
            r = resp_q.pop_front();
            n_tests++;
            if (a_resp_out_valid !== 2'(1 << r) || a_resp_out_data !== d) begin
                n_fail++;
                $display("FAIL rr_resp[%0d]: got strobe=%b data=%h expected strobe=%b data=%h",
                         t, a_resp_out_valid, a_resp_out_data, 2'(1 << r), d);
            end
            step();
            a_resp_valid = 1'b0;
        end
        a_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        int w;
        exp_t e;
        a_addr[2*AW-1:AW] = 27'h5A5A5A5;
        a_valid = 2'b10;
        a_out_ready = 1'b0;
        #1;
        w = rr_pick({6'b0, a_valid}, m_ptr2, 2);
        n_tests++;
        if (a_in_ready !== 2'(1 << w)) begin
            n_fail++;
            $display("FAIL bp_grant: got %b expected %b", a_in_ready, 2'(1 << w));
        end
        e.id = w;
        e.addr = a_addr[w*AW +: AW];
        sb_q.push_back(e);
        m_ptr2 = (w + 1) % 2;
        step();
        a_valid = 2'b11;
        e = sb_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if ({a_out_valid, a_out_id, a_out_addr, a_in_ready, a_busy} !==
                {1'b1, 1'(e.id), e.addr, 2'b00, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%h addr=%h rdy=%b busy=%b expected v=1 id=%0d addr=%h rdy=00 busy=1",
                         c, a_out_valid, a_out_id, a_out_addr, a_in_ready, a_busy, e.id, e.addr);
            end
            step();
        end
        a_out_ready = 1'b1;
        #1;
        n_tests++;
        if (a_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b expected 1", a_out_valid);
        end
        step();
        a_valid = 2'b00;
        #1;
        n_tests++;
        if ({a_out_valid, a_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_wait: got valid,busy=%b expected 01", {a_out_valid, a_busy});
        end
        a_resp_valid = 1'b1;
        a_resp_data = 64'h0123_4567_89AB_CDEF;
        #1;
        n_tests++;
        if (a_resp_out_valid !== 2'(1 << e.id)) begin
            n_fail++;
            $display("FAIL bp_resp: got %b expected %b", a_resp_out_valid, 2'(1 << e.id));
        end
        step();
        a_resp_valid = 1'b0;
        #1;
        n_tests++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: got busy=%b expected 0", a_busy);
        end
    endtask

    task automatic test_kill();
        int w;
        exp_t e;
        // Kill while presented downstream: response swallowed.
        a_addr[AW-1:0] = 27'h0ABCDEF;
        a_valid = 2'b01;
        a_out_ready = 1'b0;
        #1;
        w = rr_pick({6'b0, a_valid}, m_ptr2, 2);
        n_tests++;
        if (a_in_ready !== 2'(1 << w)) begin
            n_fail++;
            $display("FAIL kill_grant: got %b expected %b", a_in_ready, 2'(1 << w));
        end
        e.id = w;
        e.addr = a_addr[w*AW +: AW];
        sb_q.push_back(e);
        m_ptr2 = (w + 1) % 2;
        step();
        a_valid = 2'b00;
        a_kill = 1'b1;
        #1;
        e = sb_q.pop_front();
        n_tests++;
        if ({a_out_valid, a_out_id, a_out_addr} !== {1'b1, 1'(e.id), e.addr}) begin
            n_fail++;
            $display("FAIL kill_issue: got v=%b id=%h addr=%h expected v=1 id=%0d addr=%h",
                     a_out_valid, a_out_id, a_out_addr, e.id, e.addr);
        end
        step();
        a_kill = 1'b0;
        a_out_ready = 1'b1;
        step();
        a_resp_valid = 1'b1;
        #1;
        n_tests++;
        if ({a_resp_out_valid, a_busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL kill_swallow: got strobe,busy=%b expected 001", {a_resp_out_valid, a_busy});
        end
        step();
        a_resp_valid = 1'b0;
        #1;
        n_tests++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_idle: got busy=%b expected 0", a_busy);
        end

        // Kill in the same cycle as the response.
        a_addr[2*AW-1:AW] = 27'h1234567;
        a_valid = 2'b10;
        #1;
        w = rr_pick({6'b0, a_valid}, m_ptr2, 2);
        n_tests++;
        if (a_in_ready !== 2'(1 << w)) begin
            n_fail++;
            $display("FAIL kill2_grant: got %b expected %b", a_in_ready, 2'(1 << w));
        end
        e.id = w;
        e.addr = a_addr[w*AW +: AW];
        sb_q.push_back(e);
        m_ptr2 = (w + 1) % 2;
        step();
        a_valid = 2'b00;
        #1;
        e = sb_q.pop_front();
        n_tests++;
        if ({a_out_valid, a_out_id, a_out_addr} !== {1'b1, 1'(e.id), e.addr}) begin
            n_fail++;
            $display("FAIL kill2_issue: got v=%b id=%h addr=%h expected v=1 id=%0d addr=%h",
                     a_out_valid, a_out_id, a_out_addr, e.id, e.addr);
        end
        step();
        a_resp_valid = 1'b1;
        a_kill = 1'b1;
        #1;
        n_tests++;
        if (a_resp_out_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL kill2_same_cycle: got %b expected 00", a_resp_out_valid);
        end
        step();
        a_resp_valid = 1'b0;

        // Kill in IDLE, then kill coincident with an accept: both harmless.
        step();
        a_kill = 1'b0;
        a_valid = 2'b01;
        a_kill = 1'b1;
        #1;
        w = rr_pick({6'b0, a_valid}, m_ptr2, 2);
        n_tests++;
        if (a_in_ready !== 2'(1 << w)) begin
            n_fail++;
            $display("FAIL kill3_grant: got %b expected %b", a_in_ready, 2'(1 << w));
        end
        e.id = w;
        e.addr = a_addr[w*AW +: AW];
        sb_q.push_back(e);
        m_ptr2 = (w + 1) % 2;
        step();
        a_kill = 1'b0;
        a_valid = 2'b00;
        e = sb_q.pop_front();
        step();
        a_resp_valid = 1'b1;
        #1;
        n_tests++;
        if (a_resp_out_valid !== 2'(1 << e.id)) begin
            n_fail++;
            $display("FAIL kill3_resp: got %b expected %b", a_resp_out_valid, 2'(1 << e.id));
        end
        step();
        a_resp_valid = 1'b0;
    endtask

    task automatic test_spurious();
        int w;
        exp_t e;
        a_valid = 2'b00;
        a_resp_valid = 1'b1;
        #1;
        n_tests++;
        if ({a_resp_out_valid, a_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL spur_idle: got strobe,busy=%b expected 000", {a_resp_out_valid, a_busy});
        end
        step();
        a_resp_valid = 1'b0;
        n_tests++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_idle_state: got busy=%b expected 0", a_busy);
        end
        a_valid = 2'b10;
        a_out_ready = 1'b0;
        #1;
        w = rr_pick({6'b0, a_valid}, m_ptr2, 2);
        e.id = w;
        e.addr = a_addr[w*AW +: AW];
        sb_q.push_back(e);
        m_ptr2 = (w + 1) % 2;
        step();
        a_valid = 2'b00;
        a_resp_valid = 1'b1;
        #1;
        e = sb_q.pop_front();
        n_tests++;
        if ({a_out_valid, a_out_id, a_out_addr, a_resp_out_valid} !== {1'b1, 1'(e.id), e.addr, 2'b00}) begin
            n_fail++;
            $display("FAIL spur_issue: got v=%b id=%h addr=%h strobe=%b expected v=1 id=%0d addr=%h strobe=00",
                     a_out_valid, a_out_id, a_out_addr, a_resp_out_valid, e.id, e.addr);
        end
        step();
        a_resp_valid = 1'b0;
        #1;
        n_tests++;
        if ({a_out_valid, a_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL spur_issue_hold: got valid,busy=%b expected 11", {a_out_valid, a_busy});
        end
        a_out_ready = 1'b1;
        step();
        a_resp_valid = 1'b1;
        #1;
        n_tests++;
        if (a_resp_out_valid !== 2'(1 << e.id)) begin
            n_fail++;
            $display("FAIL spur_resp: got %b expected %b", a_resp_out_valid, 2'(1 << e.id));
        end
        step();
        a_resp_valid = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int w;
        exp_t e;
        a_valid = 2'b01;
        a_out_ready = 1'b1;
        #1;
        w = rr_pick({6'b0, a_valid}, m_ptr2, 2);
        e.id = w;
        e.addr = a_addr[w*AW +: AW];
        sb_q.push_back(e);
        m_ptr2 = (w + 1) % 2;
        step();
        a_valid = 2'b00;
        e = sb_q.pop_front();
        step();
        #1;
        n_tests++;
        if ({a_out_valid, a_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_wait: got valid,busy=%b expected 01", {a_out_valid, a_busy});
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_out_valid, a_busy, a_resp_out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async: got %b expected 0000", {a_out_valid, a_busy, a_resp_out_valid});
        end
        m_ptr2 = 0;
        m_ptr3 = 0;
        step();
        rst_n = 1'b1;
        a_resp_valid = 1'b1;
        #1;
        n_tests++;
        if ({a_resp_out_valid, a_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_late_resp: got strobe,busy=%b expected 000", {a_resp_out_valid, a_busy});
        end
        step();
        a_resp_valid = 1'b0;
        a_valid = 2'b11;
        #1;
        w = rr_pick({6'b0, a_valid}, m_ptr2, 2);
        n_tests++;
        if (a_in_ready !== 2'(1 << w)) begin
            n_fail++;
            $display("FAIL rst_ptr: got %b expected %b", a_in_ready, 2'(1 << w));
        end
        a_valid = 2'b00;
    endtask

    task automatic test_wrap3();
        int w;
        exp_t e;
        logic [2:0] pats [4];
        logic [DW-1:0] d;
        pats[0] = 3'b001;
        pats[1] = 3'b101;
        pats[2] = 3'b101;
        pats[3] = 3'b111;
        b_addr = {27'h3333333, 27'h2222222, 27'h0000111};
        b_out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            b_valid = pats[t];
            #1;
            w = rr_pick({5'b0, b_valid}, m_ptr3, 3);
            n_tests++;
            if (b_in_ready !== 3'(1 << w)) begin
                n_fail++;
                $display("FAIL wrap_grant[%0d]: got %b expected %b", t, b_in_ready, 3'(1 << w));
            end
            e.id = w;
            e.addr = b_addr[w*AW +: AW];
            sb_q.push_back(e);
            m_ptr3 = (w + 1) % 3;
            step();
            e = sb_q.pop_front();
            n_tests++;
            if ({b_out_valid, b_out_id, b_out_addr, b_in_ready, b_busy} !==
                {1'b1, 2'(e.id), e.addr, 3'b000, 1'b1}) begin
                n_fail++;
                $display("FAIL wrap_issue[%0d]: got v=%b id=%h addr=%h rdy=%b busy=%b expected v=1 id=%0d addr=%h rdy=000 busy=1",
                         t, b_out_valid, b_out_id, b_out_addr, b_in_ready, b_busy, e.id, e.addr);
            end
            step();
            d = 64'h1111_0000_0000_0000 + 64'(t);
            b_resp_data = d;
            b_resp_valid = 1'b1;
            #1;
            n_tests++;
            if (b_resp_out_valid !== 3'(1 << e.id) || b_resp_out_data !== d) begin
                n_fail++;
                $display("FAIL wrap_resp[%0d]: got strobe=%b data=%h expected strobe=%b data=%h",
                         t, b_resp_out_valid, b_resp_out_data, 3'(1 << e.id), d);
            end
            step();
            b_resp_valid = 1'b0;
        end
        b_valid = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_kill();
        test_spurious();
        test_reset_mid_wait();
        test_wrap3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
